// File: rtl/cmp_triple_classifier_pkg.sv
// Shared types and the priority-if classification rule for cmp_triple_classifier.
// The optional overlap reporting is enabled with CLASS_OVERLAP_ERR_EN.
package cmp_class_pkg;

    localparam int DEF_W    = 4;
    localparam int DEF_CW   = 8;
    localparam int CMP_MAXW = 32;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_A_LT_B = 2'd1,
        CLS_A_LT_C = 2'd2
    } cls_e;

    // Operands are zero-extended by the caller so one function serves any W up to CMP_MAXW.
    function automatic cls_e classify(input logic [CMP_MAXW-1:0] a,
                                      input logic [CMP_MAXW-1:0] b,
                                      input logic [CMP_MAXW-1:0] c);
        if (a < b)
            return CLS_A_LT_B;
        else if (a < c)
            return CLS_A_LT_C;
        else
            return CLS_NONE;
    endfunction

endpackage

// File: rtl/cmp_triple_classifier_if.sv
// Operand-in / class-out handshake bundle for cmp_triple_classifier.
// out_overlap exists only when CLASS_OVERLAP_ERR_EN is defined.
interface cmp_triple_classifier_if #(parameter int W = 4);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_class;
`ifdef CLASS_OVERLAP_ERR_EN
    logic         out_overlap;
`endif

    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, out_class
`ifdef CLASS_OVERLAP_ERR_EN
        , input out_overlap
`endif
    );

    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, out_class
`ifdef CLASS_OVERLAP_ERR_EN
        , output out_overlap
`endif
    );

endinterface

// File: rtl/cmp_triple_classifier_sat_cnt.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module sat_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + CW'(1);
    end

endmodule

// File: rtl/cmp_triple_classifier.sv
// Two-stage back-pressurable classifier of (a,b,c) triples with saturating per-class counts.
// Define CLASS_OVERLAP_ERR_EN to add out_overlap and the err_sticky flag.
module cmp_triple_classifier
    import cmp_class_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cmp_triple_classifier_if.slave  bus,
    input  logic                    clr_cnt,
    output logic [CW-1:0]           cnt_ab,
    output logic [CW-1:0]           cnt_ac,
    output logic [CW-1:0]           cnt_none
`ifdef CLASS_OVERLAP_ERR_EN
    ,
    output logic                    err_sticky
`endif
);

    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic [W-1:0] s1_c;
    cls_e         s1_cls;
    logic         out_valid_q;
    cls_e         cls_q;
    logic         s2_adv;
    logic         s1_adv;
    logic         out_hs;

    // Each stage may load when it is empty or its contents leave this cycle.
    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;
    assign out_hs       = out_valid_q && bus.out_ready;

    assign s1_cls = classify(CMP_MAXW'(s1_a), CMP_MAXW'(s1_b), CMP_MAXW'(s1_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a <= bus.a;
                s1_b <= bus.b;
                s1_c <= bus.c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            cls_q       <= CLS_NONE;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid)
                cls_q <= s1_cls;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_class = cls_q;

`ifdef CLASS_OVERLAP_ERR_EN
    logic ovl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovl_q <= 1'b0;
        else if (s2_adv && s1_valid)
            ovl_q <= (s1_a < s1_b) && (s1_a < s1_c);
    end

    // Sticky until cleared; a clear in the same cycle as a new overlap wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_sticky <= 1'b0;
        else if (clr_cnt)
            err_sticky <= 1'b0;
        else if (out_hs && ovl_q)
            err_sticky <= 1'b1;
    end

    assign bus.out_overlap = ovl_q;
`endif

    sat_cnt #(.CW(CW)) u_cnt_ab (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_hs && (cls_q == CLS_A_LT_B)),
        .clr   (clr_cnt),
        .q     (cnt_ab)
    );

    sat_cnt #(.CW(CW)) u_cnt_ac (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_hs && (cls_q == CLS_A_LT_C)),
        .clr   (clr_cnt),
        .q     (cnt_ac)
    );

    sat_cnt #(.CW(CW)) u_cnt_none (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_hs && (cls_q == CLS_NONE)),
        .clr   (clr_cnt),
        .q     (cnt_none)
    );

endmodule

// File: tb/tb_cmp_triple_classifier.sv
// Scoreboard bench for cmp_triple_classifier; overlap checks follow CLASS_OVERLAP_ERR_EN.
module tb_cmp_triple_classifier;

    localparam int W      = 4;
    localparam int CW     = 8;
    localparam int CW_SAT = 2;

    typedef struct {
        logic [1:0] cls;
        logic       ovl;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clr_cnt;
    logic sat_clr;
    logic [CW-1:0]     cnt_ab, cnt_ac, cnt_none;
    logic [CW_SAT-1:0] sat_ab, sat_ac, sat_none;
`ifdef CLASS_OVERLAP_ERR_EN
    logic err_sticky;
    logic sat_err;
`endif

    cmp_triple_classifier_if #(.W(W)) bus ();
    cmp_triple_classifier_if #(.W(W)) sbus ();

    cmp_triple_classifier #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .clr_cnt    (clr_cnt),
        .cnt_ab     (cnt_ab),
        .cnt_ac     (cnt_ac),
        .cnt_none   (cnt_none)
`ifdef CLASS_OVERLAP_ERR_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    cmp_triple_classifier #(.W(W), .CW(CW_SAT)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (sbus.slave),
        .clr_cnt    (sat_clr),
        .cnt_ab     (sat_ab),
        .cnt_ac     (sat_ac),
        .cnt_none   (sat_none)
`ifdef CLASS_OVERLAP_ERR_EN
        ,
        .err_sticky (sat_err)
`endif
    );

    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;
    exp_t sb[$];
    int   m_ab, m_ac, m_none;
    logic m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [1:0] ref_cls(input int a, input int b, input int c);
        if (a < b) return 2'd1;
        if (a < c) return 2'd2;
        return 2'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int a, input int b, input int c, input logic v);
        bus.a        = W'(a);
        bus.b        = W'(b);
        bus.c        = W'(c);
        bus.in_valid = v;
    endtask

    // Samples both handshakes just before the next edge, updates the model, then crosses the edge.
    task automatic stepCycle(output bit accepted);
        exp_t e;
        logic hs_out;
        #1;
        accepted = 1'b0;
        hs_out   = bus.out_valid && bus.out_ready;
        if (hs_out) begin
            checkOutput("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                pops++;
                checkOutput("out_class", 32'(bus.out_class), 32'(e.cls));
`ifdef CLASS_OVERLAP_ERR_EN
                checkOutput("out_overlap", 32'(bus.out_overlap), 32'(e.ovl));
`endif
                if (!clr_cnt) begin
                    case (e.cls)
                        2'd1:    if (m_ab   < 255) m_ab++;
                        2'd2:    if (m_ac   < 255) m_ac++;
                        default: if (m_none < 255) m_none++;
                    endcase
                    if (e.ovl) m_err = 1'b1;
                end
            end
        end
        if (clr_cnt) begin
            m_ab = 0; m_ac = 0; m_none = 0; m_err = 1'b0;
        end
        if (bus.in_valid && bus.in_ready) begin
            e.cls = ref_cls(int'(bus.a), int'(bus.b), int'(bus.c));
            e.ovl = (bus.a < bus.b) && (bus.a < bus.c);
            sb.push_back(e);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        checkOutput({tag, "_ab"},   32'(cnt_ab),   32'(m_ab));
        checkOutput({tag, "_ac"},   32'(cnt_ac),   32'(m_ac));
        checkOutput({tag, "_none"}, 32'(cnt_none), 32'(m_none));
`ifdef CLASS_OVERLAP_ERR_EN
        checkOutput({tag, "_err"},  32'(err_sticky), 32'(m_err));
`endif
    endtask

    task automatic drain_pipe(input string tag);
        bit acc;
        int guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            stepCycle(acc);
            guard++;
        end
        checkOutput({tag, "_drained"}, 32'(sb.size()), 0);
    endtask

    task automatic pulse_clear();
        bit acc;
        clr_cnt = 1'b1;
        stepCycle(acc);
        clr_cnt = 1'b0;
    endtask

    initial begin
        bit   acc;
        int   tri_a[3] = '{2, 5, 9};
        int   tri_b[3] = '{3, 3, 9};
        int   tri_c[3] = '{4, 7, 1};
        int   n, p0, sat_exp;
        logic [1:0] held;

        m_ab = 0; m_ac = 0; m_none = 0; m_err = 1'b0;
        rst_n = 1'b0; clr_cnt = 1'b0; sat_clr = 1'b0;
        applyStimulus(0, 0, 0, 1'b0);
        bus.out_ready = 1'b1;
        sbus.in_valid = 1'b0; sbus.a = '0; sbus.b = '0; sbus.c = '0;
        sbus.out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
        checkOutput("rst_out_class", 32'(bus.out_class), 0);
        check_counters("rst_cnt");
`ifdef CLASS_OVERLAP_ERR_EN
        checkOutput("rst_overlap", 32'(bus.out_overlap), 0);
`endif
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 1);

        // Basic classes with two-cycle latency
        for (int i = 0; i < 3; i++) begin
            applyStimulus(tri_a[i], tri_b[i], tri_c[i], 1'b1);
            stepCycle(acc);
            checkOutput("basic_accept", 32'(acc), 1);
            applyStimulus(0, 0, 0, 1'b0);
            stepCycle(acc);
            checkOutput("basic_latency", 32'(bus.out_valid), 1);
            stepCycle(acc);
        end
        drain_pipe("basic");
        check_counters("basic_cnt");

        // Back-pressure: two accepts fill the pipe, then results hold steady
        pulse_clear();
        bus.out_ready = 1'b0;
        applyStimulus(1, 2, 0, 1'b1);
        stepCycle(acc);
        checkOutput("bp_accept0", 32'(acc), 1);
        applyStimulus(3, 1, 8, 1'b1);
        stepCycle(acc);
        checkOutput("bp_accept1", 32'(acc), 1);
        applyStimulus(7, 7, 7, 1'b1);
        #1;
        checkOutput("bp_in_ready_low", 32'(bus.in_ready), 0);
        held = bus.out_class;
        for (int i = 0; i < 3; i++) begin
            stepCycle(acc);
            checkOutput("bp_stall_valid", 32'(bus.out_valid), 1);
            checkOutput("bp_stall_class", 32'(bus.out_class), 32'(sb[0].cls));
            checkOutput("bp_stall_no_accept", 32'(acc), 0);
        end
        checkOutput("bp_stall_first_class", 32'(held), 32'(sb[0].cls));
        bus.out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            stepCycle(acc);
            if (acc) bus.in_valid = 1'b0;
            n++;
        end
        checkOutput("bp_consecutive", 32'(n), 3);
        checkOutput("bp_total", 32'(cnt_ab + cnt_ac + cnt_none), 3);
        check_counters("bp_cnt");

        // Saturation on a CW=2 instance: five A_LT_B results
        sbus.a = 4'd0; sbus.b = 4'd1; sbus.c = 4'd0;
        sbus.in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        sbus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        sat_exp = (5 > (1 << CW_SAT) - 1) ? (1 << CW_SAT) - 1 : 5;
        checkOutput("sat_ab", 32'(sat_ab), 32'(sat_exp));
        checkOutput("sat_ac", 32'(sat_ac), 0);
        checkOutput("sat_none", 32'(sat_none), 0);

        // Clear wins over a coincident A_LT_C handshake
        pulse_clear();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) applyStimulus(5, 3, 7, 1'b1);
            else       applyStimulus(2, 3, 4, 1'b1);
            stepCycle(acc);
        end
        applyStimulus(0, 0, 0, 1'b0);
        drain_pipe("clr_pre");
        checkOutput("clr_pre_ac", 32'(cnt_ac), 2);
        check_counters("clr_pre_cnt");
        applyStimulus(5, 3, 7, 1'b1);
        stepCycle(acc);
        applyStimulus(0, 0, 0, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            stepCycle(acc);
            n++;
        end
        checkOutput("clr_out_seen", 32'(bus.out_valid), 1);
        clr_cnt = 1'b1;
        stepCycle(acc);
        clr_cnt = 1'b0;
        checkOutput("clr_ac_zero", 32'(cnt_ac), 0);
        check_counters("clr_post_cnt");

        // Streaming: 16 random triples back to back
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                          int'($urandom_range(15, 0)), 1'b1);
            stepCycle(acc);
            checkOutput("stream_accept", 32'(acc), 1);
        end
        applyStimulus(0, 0, 0, 1'b0);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            stepCycle(acc);
            n++;
        end
        checkOutput("stream_tail_cycles", 32'(n), 2);
        checkOutput("stream_results", 32'(pops - p0), 16);
        checkOutput("stream_sum", 32'(cnt_ab + cnt_ac + cnt_none), 16);
        check_counters("stream_cnt");

        // Asynchronous reset while a result is held
        bus.out_ready = 1'b0;
        applyStimulus(1, 4, 2, 1'b1);
        stepCycle(acc);
        applyStimulus(0, 0, 0, 1'b0);
        stepCycle(acc);
        checkOutput("mid_valid_before", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        m_ab = 0; m_ac = 0; m_none = 0; m_err = 1'b0;
        checkOutput("mid_valid_async", 32'(bus.out_valid), 0);
        check_counters("mid_cnt_async");
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("mid_in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 4; i++) stepCycle(acc);
        checkOutput("mid_no_stale", 32'(bus.out_valid), 0);
        checkOutput("mid_no_pops", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
